// File: rtl/shreg_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer.
// Holds the pattern mode encodings and the sequencer state enum.
package shreg_sequencer_pkg;

    localparam logic [1:0] MODE_RL   = 2'b00;   // ring-left
    localparam logic [1:0] MODE_RR   = 2'b01;   // ring-right
    localparam logic [1:0] MODE_JOHN = 2'b10;   // Johnson (twisted ring)
    localparam logic [1:0] MODE_PP   = 2'b11;   // ping-pong, zero fill

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shreg_sequencer_datapath.sv
// Shift-register datapath: WIDTH-bit pattern register plus ping-pong
// direction flag.
//   clk, rst_n : clock, async active-low reset
//   load       : capture seed, reset direction to left (has priority)
//   shift_en   : apply one shift of the selected pattern
//   mode       : pattern select
//   seed       : value captured on load
//   q          : register contents
module shreg_datapath
    import shreg_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;
    logic             dir_right;
    logic             dir_right_next;

    always_comb begin
        q_next         = q;
        dir_right_next = dir_right;
        if (load) begin
            q_next         = seed;
            dir_right_next = 1'b0;
        end else if (shift_en) begin
            case (mode)
                MODE_RL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_RR:   q_next = {q[0], q[WIDTH-1:1]};
                MODE_JOHN: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
                MODE_PP: begin
                    // Bounce when the lit bit reaches the end it is heading
                    // toward; the bounce itself already moves one position.
                    if (!dir_right && q[WIDTH-1]) begin
                        q_next         = q >> 1;
                        dir_right_next = 1'b1;
                    end else if (dir_right && q[0]) begin
                        q_next         = q << 1;
                        dir_right_next = 1'b0;
                    end else if (dir_right) begin
                        q_next = q >> 1;
                    end else begin
                        q_next = q << 1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            dir_right <= 1'b0;
        end else begin
            q         <= q_next;
            dir_right <= dir_right_next;
        end
    end

endmodule

// File: rtl/shreg_sequencer.sv
// Sequencer that runs the shift-register datapath through a programmed
// number of pattern steps, started by a level request and pausable.
//   clk, rst_n : clock, async active-low reset
//   start      : start request, honoured only in IDLE
//   mode       : pattern select, latched on start
//   seed       : initial register value, latched on start
//   steps      : number of shifts, latched on start
//   pause      : freezes q and the step counter while in RUN
//   q          : register contents
//   busy       : registered, high while a sequence is in progress
//   done       : registered one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, q holds
// LOAD  | q <= seed, counter <= steps (one cycle)
// RUN   | one shift per unpaused cycle until the counter runs out
// DONE  | sequence complete (one cycle)
//
// busy/done are the state decode delayed by one register, so they lag the
// state by a cycle: done rises the cycle after the final q value appears.
module shreg_sequencer
    import shreg_sequencer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  seed,
    input  logic [STEP_W-1:0] steps,
    input  logic              pause,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [1:0]        mode_lat;
    logic [WIDTH-1:0]  seed_lat;
    logic [STEP_W-1:0] steps_lat;
    logic [STEP_W-1:0] remaining;
    logic              load;
    logic              shift_en;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                state_next = (steps_lat == '0) ? DONE : RUN;
            end
            RUN: begin
                if (!pause) begin
                    shift_en = 1'b1;
                    if (remaining == STEP_W'(1)) state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_lat  <= '0;
            seed_lat  <= '0;
            steps_lat <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state != IDLE);
            done  <= (state == DONE);
            if (state == IDLE && start) begin
                mode_lat  <= mode;
                seed_lat  <= seed;
                steps_lat <= steps;
            end
            if (load) begin
                remaining <= steps_lat;
            end else if (shift_en) begin
                remaining <= remaining - STEP_W'(1);
            end
        end
    end

    shreg_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift_en (shift_en),
        .mode     (mode_lat),
        .seed     (seed_lat),
        .q        (q)
    );

endmodule

// File: tb/tb_shreg_sequencer.sv
// Directed testbench for shreg_sequencer.
module tb_shreg_sequencer;

    localparam logic [1:0] RL   = 2'b00;
    localparam logic [1:0] RR   = 2'b01;
    localparam logic [1:0] JOHN = 2'b10;
    localparam logic [1:0] PP   = 2'b11;
    localparam int NVEC = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] steps;
    logic       pause;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [1:0] tv_mode  [NVEC];
    logic [7:0] tv_seed  [NVEC];
    int         tv_steps [NVEC];
    logic [7:0] tv_exp   [NVEC][10];

    always #5 clk = ~clk;

    shreg_sequencer #(
        .WIDTH  (8),
        .STEP_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .seed  (seed),
        .steps (steps),
        .pause (pause),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    // Presents a one-cycle start, then scrambles the config inputs so any
    // use of them after the latch shows up as a wrong pattern.
    task automatic do_start(input logic [1:0] m, input logic [7:0] s, input logic [7:0] n);
        mode  = m;
        seed  = s;
        steps = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = m + 2'd1;
        seed  = ~s;
        steps = n + 8'd5;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        mode  = RL;
        seed  = 8'h3C;
        steps = 8'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values q=%h busy=%b done=%b expected q=00 busy=0 done=0", q, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle q=%h busy=%b done=%b expected q=00 busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_patterns();
        tv_mode[0] = RL;   tv_seed[0] = 8'h01; tv_steps[0] = 3;
        tv_exp[0]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_mode[1] = JOHN; tv_seed[1] = 8'h00; tv_steps[1] = 8;
        tv_exp[1]  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        tv_mode[2] = RR;   tv_seed[2] = 8'h81; tv_steps[2] = 2;
        tv_exp[2]  = '{8'h81, 8'hC0, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_mode[3] = PP;   tv_seed[3] = 8'h40; tv_steps[3] = 4;
        tv_exp[3]  = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        // follows a run that ended heading right: load must reset direction
        tv_mode[4] = PP;   tv_seed[4] = 8'h02; tv_steps[4] = 2;
        tv_exp[4]  = '{8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_mode[5] = RL;   tv_seed[5] = 8'h80; tv_steps[5] = 1;
        tv_exp[5]  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_mode[6] = JOHN; tv_seed[6] = 8'hFF; tv_steps[6] = 2;
        tv_exp[6]  = '{8'hFF, 8'hFE, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_mode[7] = PP;   tv_seed[7] = 8'h80; tv_steps[7] = 9;
        tv_exp[7]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        tv_mode[8] = PP;   tv_seed[8] = 8'h00; tv_steps[8] = 2;
        tv_exp[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_mode[9] = JOHN; tv_seed[9] = 8'hA5; tv_steps[9] = 0;
        tv_exp[9]  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        for (int v = 0; v < NVEC; v++) begin
            do_start(tv_mode[v], tv_seed[v], 8'(tv_steps[v]));
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_load_done done=%b expected 0", v, done);
            end
            for (int i = 0; i <= tv_steps[v]; i++) begin
                @(posedge clk); #1;
                checks++;
                if (q !== tv_exp[v][i]) begin
                    errors++;
                    $display("FAIL vec%0d_q_step%0d q=%h expected %h", v, i, q, tv_exp[v][i]);
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL vec%0d_flags_step%0d busy=%b done=%b expected busy=1 done=0", v, i, busy, done);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || q !== tv_exp[v][tv_steps[v]]) begin
                errors++;
                $display("FAIL vec%0d_done done=%b busy=%b q=%h expected done=1 busy=1 q=%h",
                         v, done, busy, q, tv_exp[v][tv_steps[v]]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== tv_exp[v][tv_steps[v]]) begin
                errors++;
                $display("FAIL vec%0d_after_done done=%b busy=%b q=%h expected done=0 busy=0 q=%h",
                         v, done, busy, q, tv_exp[v][tv_steps[v]]);
            end
        end
    endtask

    task automatic test_pause();
        pause = 1'b1;                       // held through LOAD: no effect there
        do_start(RL, 8'h01, 8'd3);
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h01) begin
            errors++;
            $display("FAIL pause_load q=%h expected 01", q);
        end
        pause = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h02) begin
            errors++;
            $display("FAIL pause_first_shift q=%h expected 02", q);
        end
        pause = 1'b1;
        start = 1'b1;                       // ignored while running
        seed  = 8'hF0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            checks++;
            if (q !== 8'h02 || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold%0d q=%h done=%b busy=%b expected q=02 done=0 busy=1", j, q, done, busy);
            end
        end
        pause = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h04) begin
            errors++;
            $display("FAIL pause_resume q=%h expected 04", q);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h08 || done !== 1'b0) begin
            errors++;
            $display("FAIL pause_last q=%h done=%b expected q=08 done=0", q, done);
        end
        pause = 1'b1;                       // DONE cycle: no effect
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || q !== 8'h08) begin
            errors++;
            $display("FAIL pause_done done=%b q=%h expected done=1 q=08", done, q);
        end
        @(posedge clk); #1;
        pause = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h08) begin
            errors++;
            $display("FAIL pause_idle done=%b busy=%b q=%h expected done=0 busy=0 q=08", done, busy, q);
        end
    endtask

    task automatic test_back_to_back();
        mode  = RL;
        seed  = 8'h01;
        steps = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_load1 q=%h busy=%b expected q=01 busy=1", q, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h02 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_shift1 q=%h done=%b expected q=02 done=0", q, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done1 done=%b expected 1", done);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h02) begin
            errors++;
            $display("FAIL b2b_gap busy=%b done=%b q=%h expected busy=0 done=0 q=02", busy, done, q);
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_retrigger q=%h busy=%b expected q=01 busy=1", q, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h02) begin
            errors++;
            $display("FAIL b2b_shift2 q=%h expected 02", q);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2 done=%b expected 1", done);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end busy=%b done=%b expected busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(JOHN, 8'h00, 8'd8);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q !== 8'h03 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre q=%h busy=%b expected q=03 busy=1", q, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async q=%h busy=%b done=%b expected q=00 busy=0 done=0", q, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            checks++;
            if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rst_idle%0d q=%h busy=%b done=%b expected q=00 busy=0 done=0", j, q, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_pause();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
